// File: rtl/kab_io_initiator.sv
// Processor-side initiator for the Kabeta IO bus: single load/store strobes with
// fixed read latency, misalignment errors, and the EIC interrupt request/ack handshake.
module kab_io_initiator #(
  parameter int RD_LATENCY     = 1,
  parameter int HOLDOFF_CYCLES = 4
) (
  input  logic        Sys_Clock,
  input  logic        Sys_Reset,
  input  logic        Cpu_Req,
  input  logic        Cpu_Wr,
  input  logic [31:0] Cpu_Addr,
  input  logic [31:0] Cpu_WrData,
  output logic        Cpu_Busy,
  output logic        Cpu_Done,
  output logic        Cpu_Err,
  output logic [31:0] Cpu_RdData,
  input  logic        Cpu_IntEnable,
  output logic        Cpu_IntPending,
  output logic        Cpu_IntId,
  input  logic        Cpu_IntTake,
  output logic [29:0] Sys_Address,
  output logic [31:0] Sys_WrData,
  output logic        Sys_WrEn,
  output logic        Sys_RdEn,
  input  logic [31:0] Sys_RdData,
  input  logic        EIC_IntReq,
  input  logic        EIC_IntId,
  output logic        EIC_IntAck
);

  localparam logic [3:0] RdLat   = 4'(RD_LATENCY);
  localparam logic [3:0] HoldOff = 4'(HOLDOFF_CYCLES);

  typedef enum logic [1:0] {B_IDLE, B_WR, B_RD, B_DONE} busState_t;
  typedef enum logic [1:0] {I_IDLE, I_PEND, I_HOLD} intState_t;

  busState_t   busState;
  intState_t   intState;
  logic [3:0]  rdCount;
  logic [3:0]  holdCount;
  logic        intPend;
  logic        cpuBusy;
  logic        cpuDone;
  logic        cpuErr;
  logic [31:0] cpuRdData;
  logic        cpuIntId;
  logic [29:0] sysAddress;
  logic [31:0] sysWrData;
  logic        sysWrEn;
  logic        sysRdEn;
  logic        intAck;

  // Bus FSM: B_DONE is the single Cpu_Done cycle shared by store, load and error paths.
  always_ff @(posedge Sys_Clock or negedge Sys_Reset) begin
    if (!Sys_Reset) begin
      busState   <= B_IDLE;
      rdCount    <= 4'd0;
      cpuBusy    <= 1'b0;
      cpuDone    <= 1'b0;
      cpuErr     <= 1'b0;
      cpuRdData  <= 32'd0;
      sysAddress <= 30'd0;
      sysWrData  <= 32'd0;
      sysWrEn    <= 1'b0;
      sysRdEn    <= 1'b0;
    end else begin
      case (busState)
        B_IDLE: begin
          if (Cpu_Req) begin
            cpuBusy <= 1'b1;
            if (Cpu_Addr[1:0] != 2'b00) begin
              // Misaligned: no bus cycle, the address/data registers keep their last value.
              cpuDone  <= 1'b1;
              cpuErr   <= 1'b1;
              busState <= B_DONE;
            end else begin
              sysAddress <= Cpu_Addr[31:2];
              if (Cpu_Wr) begin
                sysWrData <= Cpu_WrData;
                sysWrEn   <= 1'b1;
                busState  <= B_WR;
              end else begin
                sysRdEn  <= 1'b1;
                rdCount  <= RdLat;
                busState <= B_RD;
              end
            end
          end
        end
        B_WR: begin
          sysWrEn  <= 1'b0;
          cpuDone  <= 1'b1;
          busState <= B_DONE;
        end
        B_RD: begin
          sysRdEn <= 1'b0;
          if (rdCount == 4'd0) begin
            cpuRdData <= Sys_RdData;
            cpuDone   <= 1'b1;
            busState  <= B_DONE;
          end else begin
            rdCount <= rdCount - 4'd1;
          end
        end
        B_DONE: begin
          cpuDone  <= 1'b0;
          cpuErr   <= 1'b0;
          cpuBusy  <= 1'b0;
          busState <= B_IDLE;
        end
        default: busState <= B_IDLE;
      endcase
    end
  end

  // Interrupt FSM: a take outranks a withdrawal arriving in the same cycle.
  always_ff @(posedge Sys_Clock or negedge Sys_Reset) begin
    if (!Sys_Reset) begin
      intState  <= I_IDLE;
      holdCount <= 4'd0;
      intPend   <= 1'b0;
      cpuIntId  <= 1'b0;
      intAck    <= 1'b0;
    end else begin
      case (intState)
        I_IDLE: begin
          if (EIC_IntReq) begin
            intState <= I_PEND;
            intPend  <= 1'b1;
            cpuIntId <= EIC_IntId;
          end
        end
        I_PEND: begin
          if (Cpu_IntTake && Cpu_IntEnable) begin
            intState  <= I_HOLD;
            intPend   <= 1'b0;
            intAck    <= 1'b1;
            holdCount <= HoldOff;
          end else if (!EIC_IntReq) begin
            intState <= I_IDLE;
            intPend  <= 1'b0;
          end
        end
        I_HOLD: begin
          intAck <= 1'b0;
          if (holdCount == 4'd0) begin
            intState <= I_IDLE;
          end else begin
            holdCount <= holdCount - 4'd1;
          end
        end
        default: intState <= I_IDLE;
      endcase
    end
  end

  assign Cpu_Busy       = cpuBusy;
  assign Cpu_Done       = cpuDone;
  assign Cpu_Err        = cpuErr;
  assign Cpu_RdData     = cpuRdData;
  assign Cpu_IntPending = intPend & Cpu_IntEnable;
  assign Cpu_IntId      = cpuIntId;
  assign Sys_Address    = sysAddress;
  assign Sys_WrData     = sysWrData;
  assign Sys_WrEn       = sysWrEn;
  assign Sys_RdEn       = sysRdEn;
  assign EIC_IntAck     = intAck;

endmodule

// File: tb/tb_kab_io_initiator.sv
// Scoreboard bench for kab_io_initiator: random accesses against a word-memory model,
// an IO responder with fixed read latency, and a directed interrupt handshake sequence.
module tb_kab_io_initiator;
  localparam int RdLat   = 3;
  localparam int HoldOff = 4;

  logic        Sys_Clock = 1'b0;
  logic        Sys_Reset = 1'b0;
  logic        Cpu_Req = 1'b0, Cpu_Wr = 1'b0;
  logic [31:0] Cpu_Addr = '0, Cpu_WrData = '0;
  logic        Cpu_Busy, Cpu_Done, Cpu_Err;
  logic [31:0] Cpu_RdData;
  logic        Cpu_IntEnable = 1'b0, Cpu_IntTake = 1'b0;
  logic        Cpu_IntPending, Cpu_IntId;
  logic [29:0] Sys_Address;
  logic [31:0] Sys_WrData;
  logic        Sys_WrEn, Sys_RdEn;
  logic [31:0] Sys_RdData = '0;
  logic        EIC_IntReq = 1'b0, EIC_IntId = 1'b0;
  logic        EIC_IntAck;

  kab_io_initiator #(.RD_LATENCY(RdLat), .HOLDOFF_CYCLES(HoldOff)) dut (
    .Sys_Clock(Sys_Clock), .Sys_Reset(Sys_Reset),
    .Cpu_Req(Cpu_Req), .Cpu_Wr(Cpu_Wr), .Cpu_Addr(Cpu_Addr), .Cpu_WrData(Cpu_WrData),
    .Cpu_Busy(Cpu_Busy), .Cpu_Done(Cpu_Done), .Cpu_Err(Cpu_Err), .Cpu_RdData(Cpu_RdData),
    .Cpu_IntEnable(Cpu_IntEnable), .Cpu_IntPending(Cpu_IntPending), .Cpu_IntId(Cpu_IntId),
    .Cpu_IntTake(Cpu_IntTake),
    .Sys_Address(Sys_Address), .Sys_WrData(Sys_WrData), .Sys_WrEn(Sys_WrEn),
    .Sys_RdEn(Sys_RdEn), .Sys_RdData(Sys_RdData),
    .EIC_IntReq(EIC_IntReq), .EIC_IntId(EIC_IntId), .EIC_IntAck(EIC_IntAck)
  );

  always #5 Sys_Clock = ~Sys_Clock;

  int cyc = 0;
  always @(posedge Sys_Clock) cyc <= cyc + 1;

  int nVec = 0;
  int nErr = 0;

  typedef struct {int cycle; bit wr; logic [29:0] addr; logic [31:0] data;} strobe_t;
  typedef struct {int t0; int doneCyc; bit err; bit isRd; logic [31:0] rdData;} done_t;
  typedef struct {int cycle; logic [31:0] data;} rdResp_t;

  strobe_t     strobeQ[$];
  done_t       doneQ[$];
  rdResp_t     rdQ[$];
  logic [31:0] refMem[16];
  logic [31:0] ioMem[16];
  logic [31:0] expRd = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    nVec++;
    if (act !== req) begin
      nErr++;
      $display("FAIL %s: actual %h required %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic failNow(input string name, input int act, input int req);
    nVec++;
    nErr++;
    $display("FAIL %s: actual %0d required %0d (cycle %0d)", name, act, req, cyc);
  endtask

  // IO side: stores land in ioMem; a read returns the word RdLat cycles after its strobe.
  initial begin
    for (int i = 0; i < 16; i++) ioMem[i] = 32'h1111_0000 + 32'(i);
    ioMem[8] = 32'h1234_5678;
    forever begin
      @(negedge Sys_Clock);
      if (!Sys_Reset) begin
        rdQ.delete();
      end else begin
        if (Sys_WrEn) ioMem[Sys_Address[3:0]] = Sys_WrData;
        if (Sys_RdEn) rdQ.push_back('{cyc + RdLat, ioMem[Sys_Address[3:0]]});
        if (rdQ.size() > 0 && rdQ[0].cycle == cyc) begin
          Sys_RdData = rdQ[0].data;
          void'(rdQ.pop_front());
        end else begin
          Sys_RdData = $urandom;
        end
      end
    end
  end

  // Monitor: compares strobes, busy and completions against the scoreboard queues.
  strobe_t ms;
  done_t   md;
  bit      busyExp;
  always @(negedge Sys_Clock) begin
    if (!Sys_Reset) begin
      strobeQ.delete();
      doneQ.delete();
      expRd = '0;
    end else begin
      busyExp = doneQ.size() > 0 && cyc > doneQ[0].t0 && cyc <= doneQ[0].doneCyc;
      chk("busy", 32'(Cpu_Busy), 32'(busyExp));
      if (Sys_WrEn || Sys_RdEn) begin
        chk("one_strobe", 32'(Sys_WrEn & Sys_RdEn), 32'd0);
        if (strobeQ.size() == 0) begin
          chk("unexpected_strobe", {30'd0, Sys_WrEn, Sys_RdEn}, 32'd0);
        end else begin
          ms = strobeQ.pop_front();
          $display("strobe %s addr=%h data=%h cycle=%0d", Sys_WrEn ? "WR" : "RD", Sys_Address, Sys_WrData, cyc);
          chk("strobe_cycle", cyc, ms.cycle);
          chk("strobe_dir", 32'(Sys_WrEn), 32'(ms.wr));
          chk("sys_address", 32'(Sys_Address), 32'(ms.addr));
          if (ms.wr) chk("sys_wrdata", Sys_WrData, ms.data);
        end
      end
      if (strobeQ.size() > 0 && strobeQ[0].cycle < cyc) begin
        failNow("missing_strobe", cyc, strobeQ[0].cycle);
        void'(strobeQ.pop_front());
      end
      if (Cpu_Err) chk("err_with_done", 32'(Cpu_Done), 32'd1);
      if (Cpu_Done) begin
        if (doneQ.size() == 0) begin
          chk("unexpected_done", 32'(Cpu_Done), 32'd0);
        end else begin
          md = doneQ.pop_front();
          if (md.isRd) expRd = md.rdData;
          $display("done err=%0b rddata=%h cycle=%0d", Cpu_Err, Cpu_RdData, cyc);
          chk("done_cycle", cyc, md.doneCyc);
          chk("cpu_err", 32'(Cpu_Err), 32'(md.err));
          chk("cpu_rddata", Cpu_RdData, expRd);
        end
      end
      if (doneQ.size() > 0 && doneQ[0].doneCyc < cyc) begin
        failNow("missing_done", cyc, doneQ[0].doneCyc);
        void'(doneQ.pop_front());
      end
    end
  end

  // Reference model: outcome of one accepted request at cycle t0.
  task automatic expectAccess(input int t0, input bit wr, input logic [31:0] addr,
                              input logic [31:0] data, output int doneCyc);
    if (addr[1:0] != 2'b00) begin
      doneCyc = t0 + 1;
      doneQ.push_back('{t0, doneCyc, 1'b1, 1'b0, 32'd0});
    end else if (wr) begin
      doneCyc = t0 + 2;
      strobeQ.push_back('{t0 + 1, 1'b1, addr[31:2], data});
      doneQ.push_back('{t0, doneCyc, 1'b0, 1'b0, 32'd0});
      refMem[addr[5:2]] = data;
    end else begin
      doneCyc = t0 + 2 + RdLat;
      strobeQ.push_back('{t0 + 1, 1'b0, addr[31:2], 32'd0});
      doneQ.push_back('{t0, doneCyc, 1'b0, 1'b1, refMem[addr[5:2]]});
    end
  endtask

  task automatic waitIdle();
    int n = 0;
    @(negedge Sys_Clock);
    while (Cpu_Busy && n < 100) begin
      @(negedge Sys_Clock);
      n++;
    end
    if (Cpu_Busy) failNow("idle_timeout", n, 100);
  endtask

  task automatic access(input bit wr, input logic [31:0] addr, input logic [31:0] data);
    int doneCyc;
    waitIdle();
    Cpu_Req = 1'b1; Cpu_Wr = wr; Cpu_Addr = addr; Cpu_WrData = data;
    expectAccess(cyc, wr, addr, data, doneCyc);
    @(negedge Sys_Clock);
    Cpu_Req = 1'b0; Cpu_Wr = 1'($urandom); Cpu_Addr = $urandom; Cpu_WrData = $urandom;
  endtask

  // A request held high through a load: only accepted again the cycle after Cpu_Done.
  task automatic heldPair(input logic [31:0] a1, input logic [31:0] a2, input logic [31:0] d2);
    int done1, done2;
    waitIdle();
    Cpu_Req = 1'b1; Cpu_Wr = 1'b0; Cpu_Addr = a1;
    expectAccess(cyc, 1'b0, a1, 32'd0, done1);
    @(negedge Sys_Clock);
    Cpu_Wr = 1'b1; Cpu_Addr = a2; Cpu_WrData = d2;
    expectAccess(done1 + 1, 1'b1, a2, d2, done2);
    while (cyc < done1 + 2) @(negedge Sys_Clock);
    Cpu_Req = 1'b0;
  endtask

  task automatic busTraffic();
    logic [31:0] a;
    int r;
    access(1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
    access(1'b0, 32'h0000_0020, 32'd0);
    access(1'b0, 32'h0000_0022, 32'd0);
    heldPair(32'h0000_0024, 32'h0000_0028, 32'hCAFE_0001);
    for (int i = 0; i < 60; i++) begin
      r = int'($urandom_range(0, 7));
      a = {$urandom_range(0, 255) == 0 ? 26'($urandom) : 26'd0, 4'($urandom), 2'b00};
      if (r == 7) a[1:0] = 2'($urandom_range(1, 3));
      access(r < 3, a, $urandom);
      repeat ($urandom_range(0, 2)) @(negedge Sys_Clock);
    end
  endtask

  task automatic intSeq();
    @(negedge Sys_Clock);
    Cpu_IntTake = 1'b1;
    @(negedge Sys_Clock);
    Cpu_IntTake = 1'b0;
    chk("ack_take_unpending", 32'(EIC_IntAck), 32'd0);
    @(negedge Sys_Clock);
    chk("ack_take_unpending2", 32'(EIC_IntAck), 32'd0);
    EIC_IntReq = 1'b1; EIC_IntId = 1'b1; Cpu_IntEnable = 1'b0;
    @(negedge Sys_Clock);
    #1;
    chk("pending_disabled", 32'(Cpu_IntPending), 32'd0);
    chk("int_id_capture", 32'(Cpu_IntId), 32'd1);
    Cpu_IntTake = 1'b1;
    @(negedge Sys_Clock);
    Cpu_IntTake = 1'b0;
    chk("ack_take_disabled", 32'(EIC_IntAck), 32'd0);
    Cpu_IntEnable = 1'b1;
    #1;
    chk("pending_enabled", 32'(Cpu_IntPending), 32'd1);
    Cpu_IntTake = 1'b1;
    @(negedge Sys_Clock);
    Cpu_IntTake = 1'b0;
    EIC_IntId = 1'b0;
    $display("int ack=%0b pending=%0b id=%0b cycle=%0d", EIC_IntAck, Cpu_IntPending, Cpu_IntId, cyc);
    chk("int_ack", 32'(EIC_IntAck), 32'd1);
    chk("pending_after_take", 32'(Cpu_IntPending), 32'd0);
    for (int k = 1; k <= HoldOff + 1; k++) begin
      @(negedge Sys_Clock);
      chk("ack_single", 32'(EIC_IntAck), 32'd0);
      chk("pending_holdoff", 32'(Cpu_IntPending), 32'd0);
      chk("int_id_stable", 32'(Cpu_IntId), 32'd1);
    end
    @(negedge Sys_Clock);
    chk("pending_repend", 32'(Cpu_IntPending), 32'd1);
    chk("int_id_recapture", 32'(Cpu_IntId), 32'd0);
    EIC_IntReq = 1'b0;
    @(negedge Sys_Clock);
    chk("pending_withdrawn", 32'(Cpu_IntPending), 32'd0);
    chk("ack_withdrawn", 32'(EIC_IntAck), 32'd0);
    Cpu_IntTake = 1'b1;
    @(negedge Sys_Clock);
    Cpu_IntTake = 1'b0;
    chk("ack_after_withdraw", 32'(EIC_IntAck), 32'd0);
    @(negedge Sys_Clock);
    chk("ack_after_withdraw2", 32'(EIC_IntAck), 32'd0);
    Cpu_IntEnable = 1'b0;
  endtask

  task automatic checkAllZero(input string tag);
    chk({tag, "_ctrl"}, {24'd0, Cpu_Busy, Cpu_Done, Cpu_Err, Cpu_IntPending, Cpu_IntId,
                         Sys_WrEn, Sys_RdEn, EIC_IntAck}, 32'd0);
    chk({tag, "_rddata"}, Cpu_RdData, 32'd0);
    chk({tag, "_address"}, 32'(Sys_Address), 32'd0);
    chk({tag, "_wrdata"}, Sys_WrData, 32'd0);
  endtask

  task automatic resetTest();
    int doneCyc;
    EIC_IntReq = 1'b1; EIC_IntId = 1'b1;
    waitIdle();
    Cpu_Req = 1'b1; Cpu_Wr = 1'b0; Cpu_Addr = 32'h0000_0020;
    expectAccess(cyc, 1'b0, Cpu_Addr, 32'd0, doneCyc);
    @(negedge Sys_Clock);
    Cpu_Req = 1'b0;
    @(negedge Sys_Clock);
    EIC_IntReq = 1'b0;
    #2;
    Sys_Reset = 1'b0;
    #1;
    checkAllZero("reset_mid_read");
    repeat (2) @(negedge Sys_Clock);
    Sys_Reset = 1'b1;
    repeat (8) @(negedge Sys_Clock);
    access(1'b1, 32'h0000_0030, 32'h0BAD_F00D);
    waitIdle();
  endtask

  initial begin
    for (int i = 0; i < 16; i++) refMem[i] = 32'h1111_0000 + 32'(i);
    refMem[8] = 32'h1234_5678;
    repeat (2) @(negedge Sys_Clock);
    checkAllZero("reset_state");
    Sys_Reset = 1'b1;
    fork
      busTraffic();
      intSeq();
    join
    waitIdle();
    resetTest();
    repeat (5) @(negedge Sys_Clock);
    chk("queues_drained", 32'(strobeQ.size() + doneQ.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
